writeback_regfile: RTL and testbench

Writeback stage and architectural state holder for the single-cycle RV32I core. It sits downstream of memory_access and selects the result to commit (ALU value, load data or link address). It owns the 32×32 integer register file whose asynchronous read ports feed decode. It also tracks processor status (run / halt / fault) and keeps the cycle and retired-instruction counters.

---
 rtl/writeback_regfile.sv | 207 ++++++++++++++++++++
 tb/tb_writeback_regfile.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_regfile
//  Purpose  : Writeback stage and architectural state of the single-cycle
//             RV32I core. It selects the commit value (ALU result, load data
//             or link address) and holds the 32x32 integer register file.
//             It also keeps the processor status (run/halt/fault) and the
//             64-bit cycle and retired-instruction counters.
//  Ports    : clk_i, rst_n_i        clock, asynchronous active-low reset
//             opcode_i, rd_i,      current instruction fields
//             rs1_i, rs2_i, imm_i
//             valE_i, valm_i,      candidate writeback values
//             pc_plus4_i
//             imem_error_i,        fetch / data access faults
//             dmem_error_i
//             val1_o, val2_o       combinational register reads
//             wb_en_o, wb_rd_o,    write committed at the next edge
//             wb_data_o
//             stat_o, halt_o       00 AOK, 01 HLT, 10 ADR, 11 INS
//             cycle_o, instret_o   cycles in AOK, instructions retired
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
  parameter bit RESET_X0_ONLY = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] valE_i,
  input  logic [31:0] valm_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        imem_error_i,
  input  logic        dmem_error_i,
  output logic [31:0] val1_o,
  output logic [31:0] val2_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic [1:0]  stat_o,
  output logic        halt_o,
  output logic [63:0] cycle_o,
  output logic [63:0] instret_o
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_AOK = 2'b00,
    ST_HLT = 2'b01,
    ST_ADR = 2'b10,
    ST_INS = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;

  logic        w_valid_op;
  logic        w_write_class;
  logic        w_is_mem;
  logic        w_fault;
  logic        w_commit;
  logic        w_wb_en;
  logic [31:0] w_wb_data;
  logic [31:0] w_rf [0:31];
  logic        w_unused_imm;

  // Only the low 12 immediate bits distinguish ECALL/EBREAK.
  assign w_unused_imm = ^imm_i[31:12];

  // --------------------------------------------------------------------------
  // Opcode classification and writeback data select
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid_op    = 1'b0;
    w_write_class = 1'b0;
    w_wb_data     = valE_i;
    unique case (opcode_i)
      c_OP_LUI, c_OP_AUIPC, c_OP_IMM, c_OP_R: begin
        w_valid_op    = 1'b1;
        w_write_class = 1'b1;
      end
      c_OP_JAL, c_OP_JALR: begin
        w_valid_op    = 1'b1;
        w_write_class = 1'b1;
        w_wb_data     = pc_plus4_i;
      end
      c_OP_LOAD: begin
        w_valid_op    = 1'b1;
        w_write_class = 1'b1;
        w_wb_data     = valm_i;
      end
      c_OP_STORE, c_OP_BRANCH, c_OP_SYSTEM: begin
        w_valid_op    = 1'b1;
      end
      default: begin
        w_valid_op    = 1'b0;
      end
    endcase
  end

  assign w_is_mem = (opcode_i == c_OP_LOAD) || (opcode_i == c_OP_STORE);

  // Any of these stops the instruction from committing.
  assign w_fault  = imem_error_i || !w_valid_op || (dmem_error_i && w_is_mem);
  assign w_commit = (state_q == ST_AOK) && !w_fault;
  assign w_wb_en  = w_commit && w_write_class && (rd_i != 5'd0);

  assign wb_en_o   = w_wb_en;
  assign wb_rd_o   = rd_i;
  assign wb_data_o = w_wb_data;

  // --------------------------------------------------------------------------
  // Status FSM and counters
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (state_q == ST_AOK) begin
      cycle_d = cycle_q + 64'd1;
      if (w_commit) begin
        instret_d = instret_q + 64'd1;
      end
      if (imem_error_i) begin
        state_d = ST_ADR;
      end else if (!w_valid_op) begin
        state_d = ST_INS;
      end else if (dmem_error_i && w_is_mem) begin
        state_d = ST_ADR;
      end else if ((opcode_i == c_OP_SYSTEM) && (imm_i[11:1] == 11'd0)) begin
        // imm 0 (ECALL) or 1 (EBREAK): retire, then halt.
        state_d = ST_HLT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_AOK;
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign stat_o    = state_q;
  assign halt_o    = (state_q != ST_AOK);
  assign cycle_o   = cycle_q;
  assign instret_o = instret_q;

  // --------------------------------------------------------------------------
  // Register file: x0 is a constant, x1..x31 are individual registers
  // --------------------------------------------------------------------------
  assign w_rf[0] = 32'd0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] data_q;
      logic        w_we;

      assign w_we     = w_wb_en && (rd_i == gi[4:0]);
      assign w_rf[gi] = data_q;

      if (RESET_X0_ONLY) begin : g_noreset
        // Unreset storage: gate with rst_n_i so an edge during reset
        // cannot commit a pending write.
        always_ff @(posedge clk_i) begin
          if (w_we && rst_n_i) begin
            data_q <= w_wb_data;
          end
        end
      end else begin : g_reset
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            data_q <= 32'd0;
          end else if (w_we) begin
            data_q <= w_wb_data;
          end
        end
      end
    end
  endgenerate

  // No write bypass: reads see contents before the pending edge.
  assign val1_o = w_rf[rs1_i];
  assign val2_o = w_rf[rs2_i];

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_regfile
//  Purpose  : Directed self-checking bench for writeback_regfile.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i, valE_i, valm_i, pc_plus4_i;
  logic        imem_error_i, dmem_error_i;
  logic [31:0] val1_o, val2_o, wb_data_o;
  logic        wb_en_o, halt_o;
  logic [4:0]  wb_rd_o;
  logic [1:0]  stat_o;
  logic [63:0] cycle_o, instret_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  writeback_regfile #(.RESET_X0_ONLY(1'b0)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .opcode_i(opcode_i), .rd_i(rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .valE_i(valE_i),
    .valm_i(valm_i), .pc_plus4_i(pc_plus4_i), .imem_error_i(imem_error_i),
    .dmem_error_i(dmem_error_i), .val1_o(val1_o), .val2_o(val2_o),
    .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .stat_o(stat_o), .halt_o(halt_o), .cycle_o(cycle_o), .instret_o(instret_o)
  );

  task automatic idle_inputs();
    opcode_i = c_OP_STORE; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0;
    imm_i = 32'd0; valE_i = 32'd0; valm_i = 32'd0; pc_plus4_i = 32'd0;
    imem_error_i = 1'b0; dmem_error_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd,
                       input logic [31:0] e, input logic [31:0] m,
                       input logic [31:0] p4, input logic [31:0] imm);
    opcode_i = op; rd_i = rd; valE_i = e; valm_i = m; pc_plus4_i = p4; imm_i = imm;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_i = 5'd5; rs2_i = 5'd31; #1;
    checks++; if (stat_o !== 2'b00) begin errors++; $display("FAIL reset_stat: got %b expected 00", stat_o); end
    checks++; if (halt_o !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt_o); end
    checks++; if (cycle_o !== 64'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cycle_o); end
    checks++; if (instret_o !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret_o); end
    checks++; if (val1_o !== 32'd0 || val2_o !== 32'd0) begin errors++; $display("FAIL reset_regs: got %h/%h expected 0/0", val1_o, val2_o); end
  endtask

  task automatic test_basic_write();
    rs1_i = 5'd5;
    drive(c_OP_IMM, 5'd5, 32'h0000_002A, 32'h0, 32'h0, 32'h0);
    checks++; if (wb_en_o !== 1'b1 || wb_rd_o !== 5'd5 || wb_data_o !== 32'h2A) begin
      errors++; $display("FAIL imm_wb: got en=%b rd=%0d data=%h expected en=1 rd=5 data=2a", wb_en_o, wb_rd_o, wb_data_o); end
    checks++; if (val1_o !== 32'd0) begin errors++; $display("FAIL no_bypass: got %h expected 0", val1_o); end
    step();
    checks++; if (val1_o !== 32'h2A) begin errors++; $display("FAIL imm_x5: got %h expected 2a", val1_o); end
    checks++; if (instret_o !== 64'd1 || cycle_o !== 64'd1) begin
      errors++; $display("FAIL imm_counters: got instret=%0d cycle=%0d expected 1/1", instret_o, cycle_o); end
  endtask

  task automatic test_x0();
    rs1_i = 5'd0;
    drive(c_OP_IMM, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL x0_wb_en: got %b expected 0", wb_en_o); end
    step();
    checks++; if (val1_o !== 32'd0) begin errors++; $display("FAIL x0_read: got %h expected 0", val1_o); end
    checks++; if (instret_o !== 64'd2) begin errors++; $display("FAIL x0_instret: got %0d expected 2", instret_o); end
  endtask

  task automatic test_jal_load();
    drive(c_OP_JAL, 5'd1, 32'h200, 32'h0, 32'h104, 32'h0);
    checks++; if (wb_data_o !== 32'h104) begin errors++; $display("FAIL jal_data: got %h expected 104", wb_data_o); end
    step();
    drive(c_OP_LOAD, 5'd2, 32'h300, 32'hFFFF_FF80, 32'h108, 32'h0);
    checks++; if (wb_data_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_data: got %h expected ffffff80", wb_data_o); end
    step();
    rs1_i = 5'd1; rs2_i = 5'd2; #1;
    checks++; if (val1_o !== 32'h104) begin errors++; $display("FAIL jal_x1: got %h expected 104", val1_o); end
    checks++; if (val2_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_x2: got %h expected ffffff80", val2_o); end
  endtask

  task automatic test_noops();
    drive(c_OP_STORE, 5'd3, 32'h55, 32'h0, 32'h0, 32'h0);
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL store_wb_en: got %b expected 0", wb_en_o); end
    step();
    drive(c_OP_SYSTEM, 5'd4, 32'h66, 32'h0, 32'h0, 32'h5);
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL sys_wb_en: got %b expected 0", wb_en_o); end
    step();
    checks++; if (stat_o !== 2'b00 || instret_o !== 64'd6 || cycle_o !== 64'd6) begin
      errors++; $display("FAIL sys_nop: got stat=%b instret=%0d cycle=%0d expected 00/6/6", stat_o, instret_o, cycle_o); end
  endtask

  task automatic test_dmem_fault();
    rs2_i = 5'd2;
    dmem_error_i = 1'b1;
    drive(c_OP_LOAD, 5'd2, 32'h0, 32'h1234_5678, 32'h0, 32'h0);
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL dmem_wb_en: got %b expected 0", wb_en_o); end
    step();
    dmem_error_i = 1'b0;
    #1;
    checks++; if (stat_o !== 2'b10 || halt_o !== 1'b1) begin errors++; $display("FAIL dmem_stat: got %b halt=%b expected 10 halt=1", stat_o, halt_o); end
    checks++; if (val2_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL dmem_x2: got %h expected ffffff80", val2_o); end
    checks++; if (instret_o !== 64'd6 || cycle_o !== 64'd7) begin
      errors++; $display("FAIL dmem_counters: got instret=%0d cycle=%0d expected 6/7", instret_o, cycle_o); end
    drive(c_OP_IMM, 5'd2, 32'h0000_0BAD, 32'h0, 32'h0, 32'h0);
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL sticky_wb_en: got %b expected 0", wb_en_o); end
    repeat (3) step();
    checks++; if (val2_o !== 32'hFFFF_FF80 || cycle_o !== 64'd7 || stat_o !== 2'b10) begin
      errors++; $display("FAIL sticky: got x2=%h cycle=%0d stat=%b expected ffffff80/7/10", val2_o, cycle_o, stat_o); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(7'h7F, 5'd6, 32'h77, 32'h0, 32'h0, 32'h0);
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL ins_wb_en: got %b expected 0", wb_en_o); end
    step();
    checks++; if (stat_o !== 2'b11 || instret_o !== 64'd0 || cycle_o !== 64'd1) begin
      errors++; $display("FAIL ins_state: got stat=%b instret=%0d cycle=%0d expected 11/0/1", stat_o, instret_o, cycle_o); end
  endtask

  task automatic test_ecall();
    do_reset();
    drive(c_OP_LUI, 5'd9, 32'h1234_5000, 32'h0, 32'h0, 32'h0);
    step();
    drive(c_OP_SYSTEM, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    checks++; if (stat_o !== 2'b01 || halt_o !== 1'b1 || instret_o !== 64'd2) begin
      errors++; $display("FAIL ecall: got stat=%b halt=%b instret=%0d expected 01/1/2", stat_o, halt_o, instret_o); end
    rs1_i = 5'd9;
    drive(c_OP_IMM, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    checks++; if (val1_o !== 32'h1234_5000 || cycle_o !== 64'd2) begin
      errors++; $display("FAIL hlt_frozen: got x9=%h cycle=%0d expected 12345000/2", val1_o, cycle_o); end
    do_reset();
    drive(c_OP_SYSTEM, 5'd0, 32'h0, 32'h0, 32'h0, 32'h1);
    step();
    checks++; if (stat_o !== 2'b01 || instret_o !== 64'd1) begin
      errors++; $display("FAIL ebreak: got stat=%b instret=%0d expected 01/1", stat_o, instret_o); end
  endtask

  task automatic test_imem_fault();
    do_reset();
    rs1_i = 5'd5;
    imem_error_i = 1'b1;
    drive(c_OP_IMM, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    checks++; if (wb_en_o !== 1'b0) begin errors++; $display("FAIL imem_wb_en: got %b expected 0", wb_en_o); end
    step();
    imem_error_i = 1'b0;
    #1;
    checks++; if (stat_o !== 2'b10 || val1_o !== 32'd0 || instret_o !== 64'd0) begin
      errors++; $display("FAIL imem_state: got stat=%b x5=%h instret=%0d expected 10/0/0", stat_o, val1_o, instret_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    rs1_i = 5'd7;
    drive(c_OP_IMM, 5'd7, 32'h55, 32'h0, 32'h0, 32'h0);
    step();
    checks++; if (val1_o !== 32'h55) begin errors++; $display("FAIL ar_pre: got %h expected 55", val1_o); end
    drive(c_OP_IMM, 5'd7, 32'hAA, 32'h0, 32'h0, 32'h0);
    checks++; if (wb_en_o !== 1'b1) begin errors++; $display("FAIL ar_wb_en: got %b expected 1", wb_en_o); end
    #1;
    rst_n_i = 1'b0;
    #1;
    checks++; if (val1_o !== 32'd0 || cycle_o !== 64'd0 || instret_o !== 64'd0 || stat_o !== 2'b00) begin
      errors++; $display("FAIL ar_immediate: got x7=%h cycle=%0d instret=%0d stat=%b expected 0/0/0/00", val1_o, cycle_o, instret_o, stat_o); end
    step();
    checks++; if (val1_o !== 32'd0) begin errors++; $display("FAIL ar_held: got %h expected 0", val1_o); end
    idle_inputs();
    rs1_i = 5'd7;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();
    checks++; if (val1_o !== 32'd0 || cycle_o !== 64'd1) begin
      errors++; $display("FAIL ar_after: got x7=%h cycle=%0d expected 0/1", val1_o, cycle_o); end
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_write();
    test_x0();
    test_jal_load();
    test_noops();
    test_dmem_fault();
    test_illegal();
    test_ecall();
    test_imem_fault();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
